// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: access-size encoding, the
// responder state machine, and the alignment check applied at request time.
package mem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } accSize_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_BURST
  } respState_e;

  // The reserved size is treated as an error just like a misaligned access.
  function automatic logic isBadAccess(input logic [1:0] size, input logic [1:0] lowAddr);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return lowAddr[0];
      SIZE_WORD: return |lowAddr;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane handling for the responder: picks and extends the addressed lane
// on loads, and replicates store data with a matching byte-enable mask.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [31:0]   rdWord,
  input  logic [1:0]    lowAddr,
  input  logic [1:0]    size,
  input  logic          signExt,
  input  logic [DW-1:0] stData,
  output logic [DW-1:0] ldData,
  output logic [31:0]   wrWord,
  output logic [3:0]    byteEn
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    byteSel = rdWord[{lowAddr, 3'b000} +: 8];
    halfSel = lowAddr[1] ? rdWord[31:16] : rdWord[15:0];
    ldData  = '0;
    wrWord  = '0;
    byteEn  = '0;
    case (size)
      SIZE_BYTE: begin
        ldData = {{(DW-8){signExt & byteSel[7]}}, byteSel};
        wrWord = {4{stData[7:0]}};
        byteEn = 4'b0001 << lowAddr;
      end
      SIZE_HALF: begin
        ldData = {{(DW-16){signExt & halfSel[15]}}, halfSel};
        wrWord = {2{stData[15:0]}};
        byteEn = lowAddr[1] ? 4'b1100 : 4'b0011;
      end
      SIZE_WORD: begin
        ldData = DW'(rdWord);
        wrWord = stData[31:0];
        byteEn = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: single loads/stores and line-refill bursts
// served from a word-organised block RAM with byte-enable writes.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DW         = 32,
  parameter int MEM_WORDS  = 1024,
  parameter int LATENCY    = 3,
  parameter int LINE_WORDS = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_we_i,
  input  logic          req_line_i,
  input  logic [DW-1:0] req_addr_i,
  input  logic [DW-1:0] req_wdata_i,
  input  logic [1:0]    req_type_i,
  input  logic          req_sign_i,
  output logic          resp_valid_o,
  output logic [DW-1:0] resp_data_o,
  output logic          resp_last_o,
  output logic          resp_err_o,
  output logic          busy_o
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int LW = $clog2(LINE_WORDS);
  localparam logic [AW-1:0] LINE_MASK = ~(AW'(LINE_WORDS - 1));
  localparam logic [LW-1:0] LAST_BEAT = LW'(LINE_WORDS - 1);
  // The counter covers the WAIT cycles only; acceptance and RESP take the other two.
  localparam logic [3:0]    WAIT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  respState_e      stateReg, stateNext;
  logic [3:0]      waitCntReg, waitCntNext;
  logic [LW-1:0]   beatReg, beatNext, beatInc;
  logic            weReg, lineReg, errReg, signReg;
  logic [1:0]      sizeReg, lowAddrReg;
  logic [AW-1:0]   idxReg, reqIdx, reqBase, readIdx;
  logic [DW-1:0]   wdataReg, loadData;
  logic [31:0]     mem [MEM_WORDS];
  logic [31:0]     rdDataReg, wrWord;
  logic [3:0]      byteEn;
  logic            accept, reqErr, memWe;
  logic            unusedAddrBits;

  assign accept         = req_valid_i && (stateReg == ST_IDLE);
  assign reqErr         = req_line_i ? req_we_i : isBadAccess(req_type_i, req_addr_i[1:0]);
  assign reqIdx         = req_addr_i[AW+1:2];
  assign reqBase        = req_line_i ? (reqIdx & LINE_MASK) : reqIdx;
  assign beatInc        = beatReg + LW'(1);
  assign unusedAddrBits = ^req_addr_i[DW-1:AW+2];

  always_comb begin
    stateNext   = stateReg;
    waitCntNext = waitCntReg;
    beatNext    = beatReg;
    case (stateReg)
      ST_IDLE: begin
        if (accept) begin
          beatNext    = '0;
          waitCntNext = WAIT_INIT;
          if (LATENCY == 1)
            stateNext = (req_line_i && !reqErr) ? ST_BURST : ST_RESP;
          else
            stateNext = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (waitCntReg == '0)
          stateNext = (lineReg && !errReg) ? ST_BURST : ST_RESP;
        else
          waitCntNext = waitCntReg - 4'd1;
      end
      ST_RESP:  stateNext = ST_IDLE;
      ST_BURST: begin
        if (beatReg == LAST_BEAT)
          stateNext = ST_IDLE;
        else
          beatNext = beatInc;
      end
      default:  stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg   <= ST_IDLE;
      waitCntReg <= '0;
      beatReg    <= '0;
      weReg      <= 1'b0;
      lineReg    <= 1'b0;
      errReg     <= 1'b0;
      signReg    <= 1'b0;
      sizeReg    <= '0;
      lowAddrReg <= '0;
      idxReg     <= '0;
      wdataReg   <= '0;
    end else begin
      stateReg   <= stateNext;
      waitCntReg <= waitCntNext;
      beatReg    <= beatNext;
      if (accept) begin
        weReg      <= req_we_i;
        lineReg    <= req_line_i;
        errReg     <= reqErr;
        signReg    <= req_sign_i;
        sizeReg    <= req_type_i;
        lowAddrReg <= req_addr_i[1:0];
        idxReg     <= reqBase;
        wdataReg   <= req_wdata_i;
      end
    end
  end

  // The RAM read is registered, so the address issued here is the word
  // presented on the following cycle (RESP or the next burst beat).
  always_comb begin
    case (stateReg)
      ST_IDLE:  readIdx = reqBase;
      ST_BURST: readIdx = idxReg | AW'(beatInc);
      default:  readIdx = idxReg;
    endcase
  end

  assign memWe = (stateReg == ST_RESP) && weReg && !errReg && !rst;

  always_ff @(posedge clk) begin
    if (memWe) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) mem[idxReg][b*8 +: 8] <= wrWord[b*8 +: 8];
      end
    end
    rdDataReg <= mem[readIdx];
  end

  mem_lane_align #(.DW(DW)) uAlign (
    .rdWord  (rdDataReg),
    .lowAddr (lowAddrReg),
    .size    (sizeReg),
    .signExt (signReg),
    .stData  (wdataReg),
    .ldData  (loadData),
    .wrWord  (wrWord),
    .byteEn  (byteEn)
  );

  always_comb begin
    req_ready_o  = (stateReg == ST_IDLE);
    busy_o       = (stateReg != ST_IDLE);
    resp_valid_o = (stateReg == ST_RESP) || (stateReg == ST_BURST);
    resp_last_o  = (stateReg == ST_RESP) || ((stateReg == ST_BURST) && (beatReg == LAST_BEAT));
    resp_err_o   = (stateReg == ST_RESP) && errReg;
    resp_data_o  = '0;
    if (stateReg == ST_BURST)
      resp_data_o = DW'(rdDataReg);
    else if ((stateReg == ST_RESP) && !weReg && !errReg)
      resp_data_o = loadData;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: hand-computed loads, stores, line bursts,
// error responses and reset abort, all checked through one compare task.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic        req_line_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic [1:0]  req_type_i = '0;
  logic        req_sign_i = 1'b0;
  logic        resp_valid_o;
  logic [31:0] resp_data_o;
  logic        resp_last_o;
  logic        resp_err_o;
  logic        busy_o;

  int          cyc = 0;
  int          testCount = 0;
  int          failCount = 0;
  logic [31:0] expData [8];

  mem_responder dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_line_i   (req_line_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .req_type_i   (req_type_i),
    .req_sign_i   (req_sign_i),
    .resp_valid_o (resp_valid_o),
    .resp_data_o  (resp_data_o),
    .resp_last_o  (resp_last_o),
    .resp_err_o   (resp_err_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Presents a request and returns the cycle in which it was accepted.
  task automatic issue(input logic we, input logic line, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic sgn,
                       output int acc);
    int guard;
    @(negedge clk);
    req_we_i    = we;
    req_line_i  = line;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_type_i  = size;
    req_sign_i  = sgn;
    req_valid_i = 1'b1;
    guard = 0;
    while (!req_ready_o && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkVal("accept_rdy", 32'(req_ready_o), 32'd1);
    acc = cyc;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic collectBeats(input string tag, input int acc, input int expBeats, input logic expErr);
    int   n;
    int   guard;
    logic done;
    n = 0;
    guard = 0;
    done = 1'b0;
    while (!done && guard < 40) begin
      @(negedge clk);
      guard++;
      if (resp_valid_o) begin
        if (n == 0) checkVal({tag, "_lat"}, 32'(cyc - acc), 32'd3);
        checkVal({tag, "_data"}, resp_data_o, expData[n]);
        checkVal({tag, "_last"}, 32'(resp_last_o), 32'(n == expBeats - 1));
        checkVal({tag, "_err"}, 32'(resp_err_o), 32'(expErr));
        checkVal({tag, "_rdybusy"}, {30'd0, req_ready_o, busy_o}, 32'd1);
        n++;
        if (resp_last_o || n == 8) done = 1'b1;
      end
    end
    checkVal({tag, "_beats"}, 32'(n), 32'(expBeats));
    @(negedge clk);
    checkVal({tag, "_after"}, {29'd0, req_ready_o, busy_o, resp_valid_o}, 32'd4);
    $display("[TB] %s: %0d beat(s), accepted in cycle %0d", tag, n, acc);
  endtask

  task automatic single(input string tag, input logic we, input logic line,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic sgn,
                        input logic expErr, input logic [31:0] expD);
    int acc;
    issue(we, line, addr, wdata, size, sgn, acc);
    expData[0] = expD;
    collectBeats(tag, acc, 1, expErr);
  endtask

  initial begin
    int acc;
    int nv;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkVal("rst_ready", 32'(req_ready_o), 32'd1);
    checkVal("rst_busy", 32'(busy_o), 32'd0);
    checkVal("rst_flags", {29'd0, resp_valid_o, resp_last_o, resp_err_o}, 32'd0);
    checkVal("rst_data", resp_data_o, 32'd0);

    // Word store then load
    single("sw_10", 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 1'b0, 32'h0);
    single("lw_10", 1'b0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0, 32'hDEADBEEF);

    // Sub-word loads with sign/zero extension
    single("sw_80ff", 1'b1, 1'b0, 32'h10, 32'h80FF0000, 2'b10, 1'b0, 1'b0, 32'h0);
    single("lb_13_s", 1'b0, 1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 1'b0, 32'hFFFFFF80);
    single("lb_13_z", 1'b0, 1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 1'b0, 32'h00000080);
    single("lh_12_s", 1'b0, 1'b0, 32'h12, 32'h0, 2'b01, 1'b1, 1'b0, 32'hFFFF80FF);
    single("lh_12_z", 1'b0, 1'b0, 32'h12, 32'h0, 2'b01, 1'b0, 1'b0, 32'h000080FF);
    single("lb_12_s", 1'b0, 1'b0, 32'h12, 32'h0, 2'b00, 1'b1, 1'b0, 32'hFFFFFFFF);
    single("lh_10_s", 1'b0, 1'b0, 32'h10, 32'h0, 2'b01, 1'b1, 1'b0, 32'h00000000);

    // Sub-word stores touch only their lanes
    single("sb_11", 1'b1, 1'b0, 32'h11, 32'hFFFFFFAB, 2'b00, 1'b0, 1'b0, 32'h0);
    single("lw_sb", 1'b0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0, 32'h80FFAB00);
    single("sh_12", 1'b1, 1'b0, 32'h12, 32'hFFFF1234, 2'b01, 1'b0, 1'b0, 32'h0);
    single("lw_sh", 1'b0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0, 32'h1234AB00);
    single("lw_wrap", 1'b0, 1'b0, 32'h1010, 32'h0, 2'b10, 1'b0, 1'b0, 32'h1234AB00);

    // Line refill
    for (int k = 0; k < 4; k++)
      single("sw_line", 1'b1, 1'b0, 32'(32'h20 + 4 * k), 32'(k + 1), 2'b10, 1'b0, 1'b0, 32'h0);
    issue(1'b0, 1'b1, 32'h24, 32'h0, 2'b11, 1'b1, acc);
    for (int k = 0; k < 4; k++) expData[k] = 32'(k + 1);
    collectBeats("line_24", acc, 4, 1'b0);
    issue(1'b0, 1'b1, 32'h2F, 32'h0, 2'b01, 1'b0, acc);
    collectBeats("line_2f", acc, 4, 1'b0);

    // Error responses leave memory untouched
    single("sw_00", 1'b1, 1'b0, 32'h00, 32'h11223344, 2'b10, 1'b0, 1'b0, 32'h0);
    single("err_lh01", 1'b0, 1'b0, 32'h01, 32'h0, 2'b01, 1'b1, 1'b1, 32'h0);
    single("err_lnst", 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 2'b10, 1'b0, 1'b1, 32'h0);
    single("lw_20", 1'b0, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 1'b0, 32'h1);
    single("err_sw02", 1'b1, 1'b0, 32'h02, 32'h55555555, 2'b10, 1'b0, 1'b1, 32'h0);
    single("err_rsvd", 1'b0, 1'b0, 32'h00, 32'h0, 2'b11, 1'b0, 1'b1, 32'h0);
    single("lw_00", 1'b0, 1'b0, 32'h00, 32'h0, 2'b10, 1'b0, 1'b0, 32'h11223344);

    // Reset while a store waits aborts it
    single("sw_40", 1'b1, 1'b0, 32'h40, 32'hCAFEF00D, 2'b10, 1'b0, 1'b0, 32'h0);
    issue(1'b1, 1'b0, 32'h40, 32'h99999999, 2'b10, 1'b0, acc);
    rst = 1'b1;
    nv = 0;
    repeat (2) begin
      @(negedge clk);
      nv = nv + int'(resp_valid_o);
    end
    rst = 1'b0;
    @(negedge clk);
    checkVal("rstw_ready", 32'(req_ready_o), 32'd1);
    repeat (6) begin
      @(negedge clk);
      nv = nv + int'(resp_valid_o);
    end
    checkVal("rstw_novalid", 32'(nv), 32'd0);
    $display("[TB] rst_wait: store @0x40 aborted in cycle %0d", acc);
    single("lw_40", 1'b0, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 1'b0, 32'hCAFEF00D);

    // Request held valid with changing fields during a burst
    @(negedge clk);
    req_we_i    = 1'b0;
    req_line_i  = 1'b1;
    req_addr_i  = 32'h20;
    req_type_i  = 2'b10;
    req_valid_i = 1'b1;
    checkVal("hold_rdy", 32'(req_ready_o), 32'd1);
    acc = cyc;
    @(posedge clk);
    #1;
    req_we_i    = 1'b1;
    req_line_i  = 1'b0;
    req_addr_i  = 32'h28;
    req_wdata_i = 32'h77;
    req_sign_i  = 1'b1;
    for (int k = 0; k < 4; k++) expData[k] = 32'(k + 1);
    collectBeats("hold_line", acc, 4, 1'b0);
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    expData[0] = 32'h0;
    collectBeats("hold_sw", acc + 7, 1, 1'b0);
    single("lw_28", 1'b0, 1'b0, 32'h28, 32'h0, 2'b10, 1'b0, 1'b0, 32'h77);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
